// File: rtl/lsu_store_drain_pkg.sv
// rtl/lsu_store_drain_pkg.sv - shared LSU store-drain state encodings and entry field offsets
package lsu_store_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_REQ  = 2'd2,
      ST_RESP = 2'd3
   } drain_state_e;

   // Store-buffer entry layout: {Addr, Data, Mask}
   localparam int ADDR_LSB = 36;
   localparam int DATA_LSB = 4;
   localparam int MASK_LSB = 0;

endpackage

// File: rtl/lsu_store_drain_if.sv
// rtl/lsu_store_drain_if.sv - store FIFO read side and data-cache write request bundle
interface lsu_store_drain_if #(
   parameter int ENTRYWIDE = 68
);
   logic                 FifoEmpty;
   logic [ENTRYWIDE-1:0] FifoDout;
   logic                 FifoRable;
   logic                 FifoClean;
   logic                 DcReqValid;
   logic                 DcReqReady;
   logic [31:0]          DcReqAddr;
   logic [31:0]          DcReqData;
   logic [3:0]           DcReqMask;
   logic                 DcWrAck;

   modport master (
      input  FifoEmpty, FifoDout, DcReqReady, DcWrAck,
      output FifoRable, FifoClean, DcReqValid, DcReqAddr, DcReqData, DcReqMask
   );

   modport slave (
      output FifoEmpty, FifoDout, DcReqReady, DcWrAck,
      input  FifoRable, FifoClean, DcReqValid, DcReqAddr, DcReqData, DcReqMask
   );
endinterface

// File: rtl/lsu_store_drain.sv
// rtl/lsu_store_drain.sv - drains the store FIFO into the data cache one store at a time
module lsu_store_drain
   import lsu_store_drain_pkg::*;
#(
   parameter int ENTRYWIDE = 68,
   parameter int CNTWIDE   = 16
) (
   input  logic               Clk,
   input  logic               Rest,
   input  logic               FlushIn,
   lsu_store_drain_if.master  bus,
   output logic               DrainIdle,
   output logic [CNTWIDE-1:0] StoreCnt
);

   drain_state_e         state_q, state_d;
   logic [ENTRYWIDE-1:0] entry;
   logic [31:0]          req_addr;
   logic [31:0]          req_data;
   logic [3:0]           req_mask;
   logic                 abort;

   assign entry = bus.FifoDout;

   // A flush discards the entry unless the cache already took it this cycle
   assign abort = FlushIn &&
                  ((state_q == ST_LOAD) || ((state_q == ST_REQ) && !bus.DcReqReady));

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!bus.FifoEmpty && !FlushIn) state_d = ST_LOAD;
         ST_LOAD: state_d = FlushIn ? ST_IDLE : ST_REQ;
         ST_REQ: begin
            if (bus.DcReqReady)  state_d = ST_RESP;
            else if (FlushIn)    state_d = ST_IDLE;
         end
         ST_RESP: if (bus.DcWrAck) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.FifoRable  = Rest && (state_q == ST_IDLE) && !bus.FifoEmpty && !FlushIn;
      bus.FifoClean  = Rest && FlushIn;
      bus.DcReqValid = (state_q == ST_REQ);
      bus.DcReqAddr  = req_addr & 32'hFFFF_FFFC;
      bus.DcReqData  = req_data;
      bus.DcReqMask  = req_mask;
      DrainIdle      = (state_q == ST_IDLE) && bus.FifoEmpty;
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         req_addr <= '0;
         req_data <= '0;
         req_mask <= '0;
      end else if (abort) begin
         req_addr <= '0;
         req_data <= '0;
         req_mask <= '0;
      end else if (state_q == ST_LOAD) begin
         req_addr <= entry[ADDR_LSB +: 32];
         req_data <= entry[DATA_LSB +: 32];
         req_mask <= entry[MASK_LSB +: 4];
      end
   end

   // Wraps naturally at 2^CNTWIDE
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         StoreCnt <= '0;
      end else if ((state_q == ST_RESP) && bus.DcWrAck) begin
         StoreCnt <= StoreCnt + CNTWIDE'(1);
      end
   end

endmodule

// File: doc/lsu_store_drain.md
LSU_STORE_DRAIN -- requirements
Module: lsu_store_drain

Interface
REQ-001 SHALL have parameter ENTRYWIDE, default 68, meaning the width of a store-buffer entry: {Addr[67:36], Data[35:4], Mask[3:0]}.
REQ-002 SHALL have parameter CNTWIDE, default 16, meaning the width of the completed-store counter.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Rest  input  1  reset, asynchronous and active-low.
REQ-005 FifoEmpty  input  1  empty flag from the upstream store FIFO.
REQ-006 FifoDout  input  ENTRYWIDE  registered FIFO read data, valid the cycle after FifoRable.
REQ-007 FifoRable  output  1  pop strobe to the FIFO.
REQ-008 FifoClean  output  1  clears the FIFO pointers.
REQ-009 FlushIn  input  1  pipeline flush request; discards speculative stores.
REQ-010 DcReqValid  output  1  write request valid to the data cache.
REQ-011 DcReqReady  input  1  data cache accepts the request.
REQ-012 DcReqAddr  output  32  store address, word aligned.
REQ-013 DcReqData  output  32  store data.
REQ-014 DcReqMask  output  4  byte-enable mask.
REQ-015 DcWrAck  input  1  write completion from the data cache.
REQ-016 DrainIdle  output  1  high when the FSM is in IDLE and FifoEmpty is high; used by fences.
REQ-017 StoreCnt  output  CNTWIDE  number of completed stores.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, REQ, RESP.
REQ-019 IDLE: when FifoEmpty=0 and FlushIn=0, SHALL drive FifoRable=1 for one cycle and go to LOAD; otherwise SHALL stay in IDLE.
REQ-020 LOAD: SHALL capture FifoDout into the request register and go to REQ; FifoRable SHALL be 0.
REQ-021 REQ: SHALL hold DcReqValid=1 with stable Addr/Data/Mask until DcReqValid && DcReqReady, then SHALL go to RESP.
REQ-022 RESP: SHALL hold DcReqValid=0 and, on DcWrAck=1, SHALL increment StoreCnt and go to IDLE.
REQ-023 Minimum per-store latency SHALL be 4 cycles (IDLE pop, LOAD, REQ with Ready=1, RESP with Ack=1), so at most one store is outstanding.
REQ-024 StoreCnt SHALL wrap from 2^CNTWIDE-1 to 0 without saturation.
REQ-025 FlushIn in IDLE, LOAD or REQ before the handshake SHALL pulse FifoClean for one cycle, drop any captured entry, deassert DcReqValid next cycle, and go to IDLE.
REQ-026 FlushIn in RESP, or in the same cycle as the REQ handshake, SHALL NOT abort the accepted store: FifoClean SHALL pulse, the FSM SHALL wait for DcWrAck, then StoreCnt SHALL increment.
REQ-027 DcWrAck outside RESP SHALL be ignored.
REQ-028 FifoRable SHALL never be asserted while FifoEmpty=1 or FlushIn=1.
REQ-029 DcReqAddr[1:0] SHALL be driven 0.

Reset
REQ-030 Rest=0 SHALL asynchronously force state IDLE, StoreCnt=0, request register=0, FifoRable=0, FifoClean=0, DcReqValid=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no StoreCnt update; after release, DrainIdle SHALL follow FifoEmpty.

Structure
REQ-032 State encodings and entry field offsets (ADDR_LSB=36, DATA_LSB=4, MASK_LSB=0) SHALL live in the shared LSU package/include alongside IPsetting.v.
REQ-033 No sub-module is required; the FSM and datapath register SHALL be a single module.

Verification
REQ-034 One entry {Addr=0x1000_0004, Data=0xDEAD_BEEF, Mask=0xF}, Ready=1, Ack next cycle -> the entry is popped once, Valid is high for 1 cycle with those values, and StoreCnt=1.
REQ-035 Ready held 0 for 5 cycles -> DcReqValid stays high for 6 cycles with stable payload; exactly one handshake occurs.
REQ-036 FlushIn in REQ before Ready -> one FifoClean pulse, DcReqValid=0 next cycle, StoreCnt unchanged, FSM in IDLE.
REQ-037 FlushIn in RESP -> one FifoClean pulse, the FSM waits for Ack, and StoreCnt increments by 1.
REQ-038 CNTWIDE=4, 17 stores -> StoreCnt reads 1.
REQ-039 Rest low in REQ -> DcReqValid=0 immediately, with no clock edge required.
